pwm_duty_updown_ctrl: RTL and testbench

Parametrised, fully synchronous up/down duty-cycle controller for the PWM datapath. Two asynchronous push-button inputs are synchronised and edge-detected, then step a WIDTH-bit duty register with either saturation or wrap-around. A built-in PWM generator consumes the duty value through a shadow register, so duty changes never glitch mid-period.

---
 rtl/pwm_duty_updown_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pwm_duty_updown_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_updown_ctrl.sv
// rtl/pwm_duty_updown_ctrl.sv - up/down duty-cycle controller with glitch-free PWM generator
//
// Purpose: two asynchronous push buttons are synchronised and edge-detected.
// Each accepted edge steps a WIDTH-bit duty register, either saturating or wrapping.
// A PWM generator reads the duty through a shadow register, so a change of duty
// only takes effect at the next period boundary.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, a held button
// generates repeat steps.
//
// Ports:
//   clk_f         in   system clock; all state changes on the rising edge
//   reset_f       in   asynchronous active-high reset
//   up_f, down_f  in   raw buttons, asynchronous to clk_f
//   enable_f      in   0 = button events are discarded
//   load_f        in   1 = out_f takes load_val_f (highest priority)
//   load_val_f    in   value for load_f
//   out_f         out  commanded duty value
//   at_max_f      out  out_f is all ones
//   at_min_f      out  out_f is zero
//   step_pulse_f  out  one-cycle pulse when a button step changed out_f
//   pwm_f         out  registered PWM output, period 2^WIDTH cycles
module pwm_duty_updown_ctrl #(
  parameter int WIDTH         = 3,
  parameter int STEP          = 1,
  parameter int WRAP          = 0,
  parameter int SYNC_STAGES   = 2,
  parameter int INIT          = 0,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic             clk_f,
  input  logic             reset_f,
  input  logic             up_f,
  input  logic             down_f,
  input  logic             enable_f,
  input  logic             load_f,
  input  logic [WIDTH-1:0] load_val_f,
  output logic [WIDTH-1:0] out_f,
  output logic             at_max_f,
  output logic             at_min_f,
  output logic             step_pulse_f,
  output logic             pwm_f
);

  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  // Unsupported parameter combinations elaborate this empty marker block.
  if (SYNC_STAGES < 2 || STEP < 1 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_cfg_unsupported
  end

  // Button synchronisers. The *_last flops keep the previous value of the
  // last stage for rising-edge detection.
  logic [SYNC_STAGES-1:0] up_sync, dn_sync;
  logic                   up_last, dn_last;

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      up_sync <= '0;
      dn_sync <= '0;
      up_last <= 1'b0;
      dn_last <= 1'b0;
    end else begin
      up_sync <= {up_sync[SYNC_STAGES-2:0], up_f};
      dn_sync <= {dn_sync[SYNC_STAGES-2:0], down_f};
      up_last <= up_sync[SYNC_STAGES-1];
      dn_last <= dn_sync[SYNC_STAGES-1];
    end
  end

  logic up_lvl, dn_lvl, up_rise, dn_rise, up_ev, dn_ev;
  assign up_lvl  = up_sync[SYNC_STAGES-1];
  assign dn_lvl  = dn_sync[SYNC_STAGES-1];
  assign up_rise = up_lvl & ~up_last;
  assign dn_rise = dn_lvl & ~dn_last;

`ifdef AUTO_REPEAT_EN
  // Each counter holds the number of cycles since the rise while its button
  // is the only one held. After a repeat, the counter is rewound so that the
  // next repeat fires REPEAT_CYCLES later.
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_V   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REWIND_V = CW'(HOLD_CYCLES - REPEAT_CYCLES + 1);

  logic [CW-1:0] up_cnt, dn_cnt;
  logic          up_held, dn_held, up_rep, dn_rep;

  assign up_held = up_lvl & ~dn_lvl & ~load_f;
  assign dn_held = dn_lvl & ~up_lvl & ~load_f;
  assign up_rep  = up_held & (up_cnt == HOLD_V);
  assign dn_rep  = dn_held & (dn_cnt == HOLD_V);

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      up_cnt <= '0;
      dn_cnt <= '0;
    end else begin
      if (!up_held)    up_cnt <= '0;
      else if (up_rep) up_cnt <= REWIND_V;
      else             up_cnt <= up_cnt + 1'b1;
      if (!dn_held)    dn_cnt <= '0;
      else if (dn_rep) dn_cnt <= REWIND_V;
      else             dn_cnt <= dn_cnt + 1'b1;
    end
  end

  assign up_ev = up_rise | up_rep;
  assign dn_ev = dn_rise | dn_rep;
`else
  assign up_ev = up_rise;
  assign dn_ev = dn_rise;
`endif

  // Step arithmetic. The saturation test is written so that it never overflows.
  logic [WIDTH-1:0] inc_v, dec_v, next_out;
  logic             step_chg;

  always_comb begin
    inc_v = out_f + STEP_V;
    dec_v = out_f - STEP_V;
    if (WRAP == 0) begin
      if (out_f > (MAX_V - STEP_V)) inc_v = MAX_V;
      if (out_f < STEP_V)           dec_v = '0;
    end
  end

  // Simultaneous up and down events cancel each other.
  always_comb begin
    next_out = out_f;
    step_chg = 1'b0;
    if (load_f) begin
      next_out = load_val_f;
    end else if (enable_f && (up_ev ^ dn_ev)) begin
      next_out = up_ev ? inc_v : dec_v;
      step_chg = (next_out != out_f);
    end
  end

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      out_f        <= INIT_V;
      step_pulse_f <= 1'b0;
    end else begin
      out_f        <= next_out;
      step_pulse_f <= step_chg;
    end
  end

  assign at_max_f = (out_f == MAX_V);
  assign at_min_f = (out_f == '0);

  // PWM generator. The shadow register is loaded only when the phase wraps,
  // so every period uses one duty value from start to end.
  logic [WIDTH-1:0] phase, shadow;

  always_ff @(posedge clk_f or posedge reset_f) begin
    if (reset_f) begin
      phase  <= '0;
      shadow <= INIT_V;
      pwm_f  <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      if (phase == MAX_V) shadow <= out_f;
      pwm_f <= (phase < shadow);
    end
  end

endmodule

// File: tb/tb_pwm_duty_updown_ctrl.sv
// tb/tb_pwm_duty_updown_ctrl.sv - scoreboard bench for pwm_duty_updown_ctrl
module tb_pwm_duty_updown_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       up = 1'b0, dn = 1'b0, en = 1'b1, ld = 1'b0;
  logic [2:0] lv = '0;
  logic [2:0] out;
  logic       at_max, at_min, pulse, pwm;

  // Shared stimulus for the two STEP=3 instances (wrap and saturate)
  logic       au = 1'b0, ad = 1'b0, al = 1'b0;
  logic [2:0] alv = '0;
  logic [2:0] w_out, s_out;
  logic       w_max, w_min, w_pulse, w_pwm, s_max, s_min, s_pulse, s_pwm;

  pwm_duty_updown_ctrl #(.WIDTH(3), .STEP(1), .WRAP(0), .SYNC_STAGES(2), .INIT(0),
                         .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut (
    .clk_f(clk), .reset_f(rst), .up_f(up), .down_f(dn), .enable_f(en),
    .load_f(ld), .load_val_f(lv), .out_f(out), .at_max_f(at_max),
    .at_min_f(at_min), .step_pulse_f(pulse), .pwm_f(pwm));

  pwm_duty_updown_ctrl #(.WIDTH(3), .STEP(3), .WRAP(1), .SYNC_STAGES(2), .INIT(0),
                         .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut_wrap (
    .clk_f(clk), .reset_f(rst), .up_f(au), .down_f(ad), .enable_f(1'b1),
    .load_f(al), .load_val_f(alv), .out_f(w_out), .at_max_f(w_max),
    .at_min_f(w_min), .step_pulse_f(w_pulse), .pwm_f(w_pwm));

  pwm_duty_updown_ctrl #(.WIDTH(3), .STEP(3), .WRAP(0), .SYNC_STAGES(2), .INIT(0),
                         .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut_sat (
    .clk_f(clk), .reset_f(rst), .up_f(au), .down_f(ad), .enable_f(1'b1),
    .load_f(al), .load_val_f(alv), .out_f(s_out), .at_max_f(s_max),
    .at_min_f(s_min), .step_pulse_f(s_pulse), .pwm_f(s_pwm));

  int total = 0;
  int bad = 0;
  int sb_q[$];
  int pulses = 0;
  int model = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_model(input int cur, input bit inc, input int step, input bit wrap);
    if (inc) return wrap ? (cur + step) % 8 : ((cur > 7 - step) ? 7 : cur + step);
    else     return wrap ? (cur - step + 8) % 8 : ((cur < step) ? 0 : cur - step);
  endfunction

  // Each step pulse pops the next expected duty value from the queue.
  always @(negedge clk) begin
    if (!rst && pulse) begin
      pulses++;
      if (sb_q.size() == 0) check_val("pulse_unexpected_sb_size", sb_q.size(), 1);
      else check_val("sb_step", int'(out), sb_q.pop_front());
    end
  end

  task automatic press(input bit u, input bit d, input int hold);
    int e;
    if (en && (u ^ d)) begin
      e = step_model(model, u, 1, 1'b0);
      if (e != model) sb_q.push_back(e);
      model = e;
    end
    @(posedge clk); #1 up = u; dn = d;
    repeat (hold) @(posedge clk);
    #1 up = 1'b0; dn = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic load(input int v);
    @(posedge clk); #1 ld = 1'b1; lv = 3'(v);
    @(posedge clk); #1 ld = 1'b0;
    model = v;
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(pwm);
    end
  endtask

  task automatic aux_press(input bit u);
    @(posedge clk); #1 au = u; ad = ~u;
    repeat (2) @(posedge clk);
    #1 au = 1'b0; ad = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2, p0, prevv, hold_exp;
    bit found;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out", int'(out), 0);
    check_val("rst_at_min", int'(at_min), 1);
    check_val("rst_at_max", int'(at_max), 0);
    check_val("rst_pwm", int'(pwm), 0);
    check_val("rst_pulse", int'(pulse), 0);
    rst = 1'b0;

    // Asynchronous reset applied between clock edges
    load(5);
    @(negedge clk);
    check_val("load5", int'(out), 5);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_out", int'(out), 0);
    check_val("async_rst_min", int'(at_min), 1);
    check_val("async_rst_pwm", int'(pwm), 0);
    @(negedge clk) rst = 1'b0;
    model = 0;
    repeat (5) @(posedge clk);
    #1 check_val("post_rst_idle", int'(out), 0);

    // Nine up presses. The first press also checks the two-edge latency.
    p0 = pulses;
    sb_q.push_back(1);
    model = 1;
    @(posedge clk); #1 up = 1'b1;
    @(posedge clk);
    @(negedge clk) check_val("lat_k", int'(out), 0);
    @(negedge clk) check_val("lat_k1", int'(out), 0);
    @(negedge clk) check_val("lat_k2", int'(out), 1);
    up = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 2);
    #1;
    check_val("nine_up_out", int'(out), 7);
    check_val("nine_up_at_max", int'(at_max), 1);
    check_val("nine_up_pulses", pulses - p0, 7);

    // Simultaneous rises, disabled input, one down step
    load(4);
    press(1'b1, 1'b1, 2);
    #1 check_val("both_rise", int'(out), 4);
    en = 1'b0;
    press(1'b1, 1'b0, 2);
    #1 check_val("disabled", int'(out), 4);
    en = 1'b1;
    press(1'b0, 1'b1, 2);
    #1 check_val("down_one", int'(out), 3);
    load(0);
    press(1'b0, 1'b1, 2);
    #1 check_val("down_sat_min", int'(at_min), 1);

    // STEP=3, wrap and saturate
    @(posedge clk); #1 al = 1'b1; alv = 3'd6;
    @(posedge clk); #1 al = 1'b0;
    aux_press(1'b1);
    check_val("wrap_up", int'(w_out), step_model(6, 1'b1, 3, 1'b1));
    check_val("sat_up", int'(s_out), step_model(6, 1'b1, 3, 1'b0));
    aux_press(1'b0);
    check_val("wrap_down", int'(w_out), 6);
    check_val("sat_down", int'(s_out), 4);

    // PWM duty and shadow behaviour
    load(3);
    repeat (20) @(posedge clk);
    count_high(8, c);
    check_val("pwm_3of8", c, 3);
    found = 1'b0;
    prevv = 1;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (pwm && prevv == 0) found = 1'b1;
      else prevv = int'(pwm);
    end
    check_val("pwm_edge_found", int'(found), 1);
    c1 = int'(pwm);
    c2 = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (i < 8) c1 += int'(pwm);
      else c2 += int'(pwm);
      if (i == 2) begin ld = 1'b1; lv = 3'd5; end
      if (i == 3) ld = 1'b0;
    end
    model = 5;
    check_val("pwm_cur_period", c1, 3);
    check_val("pwm_next_period", c2, 5);
    load(0);
    repeat (20) @(posedge clk);
    count_high(16, c);
    check_val("pwm_zero", c, 0);
    load(7);
    repeat (20) @(posedge clk);
    count_high(8, c);
    check_val("pwm_7of8", c, 7);

    // Held button: extra steps only with auto-repeat enabled
    load(0);
`ifdef AUTO_REPEAT_EN
    hold_exp = 4;
`else
    hold_exp = 1;
`endif
    for (int i = 1; i <= hold_exp; i++) sb_q.push_back(i);
    model = hold_exp;
    @(posedge clk); #1 up = 1'b1;
    repeat (10) @(posedge clk);
    #1 up = 1'b0;
    repeat (8) @(posedge clk);
    #1 check_val("hold_out", int'(out), hold_exp);
    repeat (10) @(posedge clk);
    #1 check_val("hold_release", int'(out), hold_exp);

    check_val("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
